window_watchdog_mips: RTL and testbench
=======================================

# window_watchdog_mips

Windowed watchdog supervisor for the single-cycle MIPS core. It receives kick (`i_clrwdt`) and period-write strobes from the datapath, counts cycles since the last valid kick, and drives a stretched hardware-reset pulse back into the datapath reset network. A kick that arrives too late or too early fires the reset. The block's own state is cleared only by the external `i_reset`, never by the reset it generates, so its period, window and fault cause survive a watchdog reset.

## Interface
- `DEFAULT_PERIOD`, 32'd1000, timeout period loaded on `i_reset`
- `DEFAULT_WINDOW`, 32'd0, window-open count loaded on `i_reset`; 0 disables early-kick checking
- `i_clk`  in  1  system clock; one clock domain
- `i_reset`  in  1  synchronous, active-high reset
- `i_clrwdt`  in  1  kick strobe; level-sampled every cycle (the datapath drives it high for each all-zero instruction)
- `i_wait_period`  in  32  new timeout period
- `i_wait_period_w_en`  in  1  load `i_wait_period` into the period register
- `i_window_open`  in  32  new window-open count
- `i_window_w_en`  in  1  load `i_window_open` into the window register
- `i_rst_period`  in  32  reset pulse length in cycles
- `o_hardware_rst`  out  1  registered reset request to the datapath
- `o_count`  out  32  current cycle counter
- `o_state`  out  1  0 = RUN, 1 = FIRE
- `o_cause`  out  2  sticky cause of the last fire: 0 none, 1 timeout, 2 early kick
- `o_fire_cnt`  out  8  number of fires since `i_reset`; saturates at 255

## Operation
- **Registers:** `period`, `window`, `count`, `rst_len`, `state`, `cause`, `fire_cnt`.
- **Zero values:** a `period` write of 0 is stored as 1. An `rst_len` of 0 is treated as 1.
- **RUN:**
  - `count` increments by 1 each cycle.
  - Valid kick (`i_clrwdt` high and (`window` == 0 or `count` >= `window`)): `count` <= 0.
  - Early kick (`i_clrwdt` high, `window` != 0 and `count` < `window`): go to FIRE, `cause` <= 2.
  - Timeout (`count` == `period` - 1 with no valid kick this cycle): go to FIRE, `cause` <= 1.
- **Period write:** `i_wait_period_w_en` updates `period` and forces `count` <= 0.
  - It takes priority over a simultaneous kick, early kick or timeout, so no fire occurs that cycle.
- **Window write:** `i_window_w_en` updates `window` only; it takes effect on the next comparison.
  - If `window` >= `period`, every kick is early. This is legal and is not checked.
- **Entry to FIRE:** `rst_len` <= `i_rst_period`, `count` <= 0, `fire_cnt` increments.
- **FIRE:**
  - `o_hardware_rst` is 1 for exactly `rst_len` consecutive cycles.
  - `i_clrwdt` and both write enables are ignored.
  - After the last cycle, return to RUN with `count` = 0.
- **Retained across a watchdog reset:** `period`, `window` and `cause`.

## Timing
- **Reset values (the cycle after `i_reset` is sampled high):**
  - `o_hardware_rst` = 0, `o_count` = 0, `o_state` = 0, `o_cause` = 0, `o_fire_cnt` = 0
  - `period` = `DEFAULT_PERIOD`, `window` = `DEFAULT_WINDOW`
- **Fire latency:** the violation is detected at edge N. `o_state` and `o_hardware_rst` read 1 after edge N, and `o_hardware_rst` falls after edge N + `rst_len`.
- **Kick latency:** a kick sampled at edge N shows `o_count` = 0 after edge N and 1 after edge N+1.
- **Continuous kicks:**
  - With `window` = 0, `i_clrwdt` held high keeps `count` at 0 indefinitely.
  - With `window` = W > 0, kicks every cycle fire an early-kick reset on the second kick.
- **`i_reset` during FIRE:** `o_hardware_rst` drops after the same edge; the pulse is not completed.
- **Counter overflow:** `count` cannot exceed `period` - 1 in RUN, so no wrap-around occurs.

## Structure
- **Package `wdt_pkg`:**
  - state encoding `WDT_RUN` and `WDT_FIRE`
  - cause codes `WDT_CAUSE_NONE`, `WDT_CAUSE_TIMEOUT`, `WDT_CAUSE_EARLY`
  - width constant `WDT_W` = 32
- **Sub-module `wdt_pulse_stretcher`:**
  - Loads a length on a `start` strobe, holds its output high for that many cycles, and signals `done`.
  - Treats a length of 0 as 1.
  - Clears on `i_reset`.
- **Top level:** holds the period/window registers, the counter, the FSM and the status registers.

## Test plan
- **Defaults:** `i_reset`, then no kicks with `DEFAULT_PERIOD` = 10 and `i_rst_period` = 3 → `o_hardware_rst` rises after edge 10, lasts exactly 3 cycles, `o_cause` = 1, `o_fire_cnt` = 1.
- **Periodic kicks:** period 8, one kick every 5 cycles for 100 cycles → `o_hardware_rst` stays 0 and `o_count` never exceeds 5.
- **Early kick:** window 4, period 8, kick at `count` = 2 → fire on the next edge with `o_cause` = 2. Kicking at `count` = 4 instead causes no fire and `o_count` returns to 0.
- **Write vs. timeout:** a period write of 20 in the same cycle as `count` = `period` - 1 → no fire, `o_count` = 0, and the next timeout occurs 20 cycles later. A period write of 0 gives a fire on every cycle of RUN.
- **Reset mid-FIRE:** `i_rst_period` = 10, assert `i_reset` on the 4th FIRE cycle → `o_hardware_rst` = 0 on the next cycle and all registers are at their reset values.
- **Kicks ignored in FIRE:** `i_clrwdt` held high throughout a 5-cycle FIRE → the pulse still lasts 5 cycles, and `o_fire_cnt` increments only once.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and constants for the windowed watchdog supervisor.
package wdt_pkg;

  localparam int WDT_W = 32;
  localparam logic [WDT_W-1:0] WDT_ONE = {{(WDT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    WDT_RUN  = 1'b0,
    WDT_FIRE = 1'b1
  } wdt_state_e;

  typedef enum logic [1:0] {
    WDT_CAUSE_NONE    = 2'd0,
    WDT_CAUSE_TIMEOUT = 2'd1,
    WDT_CAUSE_EARLY   = 2'd2
  } wdt_cause_e;

  // Lengths and periods of zero are meaningless; they are promoted to one.
  function automatic logic [WDT_W-1:0] wdt_nonzero(input logic [WDT_W-1:0] v);
    return (v == '0) ? WDT_ONE : v;
  endfunction

endpackage

// File: rtl/wdt_pulse_stretcher.sv
// Holds pulse high for a loaded number of cycles; done marks the final cycle.
module wdt_pulse_stretcher
  import wdt_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             start,
  input  logic [WDT_W-1:0] len,
  output logic             pulse,
  output logic             done
);

  logic [WDT_W-1:0] remaining;

  // NOTE: sequential state uses non-blocking assignments and a synchronous
  // reset, so every register here updates only on the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pulse     <= 1'b0;
      remaining <= '0;
    end else if (start) begin
      pulse     <= 1'b1;
      remaining <= wdt_nonzero(len) - WDT_ONE;
    end else if (pulse) begin
      if (remaining == '0) begin
        pulse <= 1'b0;
      end else begin
        remaining <= remaining - WDT_ONE;
      end
    end
  end

  assign done = pulse && (remaining == '0);

endmodule

// File: rtl/window_watchdog_mips.sv
// Windowed watchdog: counts cycles between kicks and fires a stretched reset
// on a late or early kick. Only i_reset clears its own state.
module window_watchdog_mips
  import wdt_pkg::*;
#(
  parameter logic [WDT_W-1:0] DEFAULT_PERIOD = 32'd1000,
  parameter logic [WDT_W-1:0] DEFAULT_WINDOW = 32'd0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clrwdt,
  input  logic [WDT_W-1:0] i_wait_period,
  input  logic             i_wait_period_w_en,
  input  logic [WDT_W-1:0] i_window_open,
  input  logic             i_window_w_en,
  input  logic [WDT_W-1:0] i_rst_period,
  output logic             o_hardware_rst,
  output logic [WDT_W-1:0] o_count,
  output logic             o_state,
  output logic [1:0]       o_cause,
  output logic [7:0]       o_fire_cnt
);

  wdt_state_e       state_q, state_d;
  wdt_cause_e       cause_q, cause_d;
  logic [WDT_W-1:0] period_q, period_d;
  logic [WDT_W-1:0] window_q, window_d;
  logic [WDT_W-1:0] count_q, count_d;
  logic [7:0]       fire_cnt_q, fire_cnt_d;
  logic             fire_start;
  logic             pulse_done;
  logic             kick_valid;
  logic             kick_early;
  logic             timeout;

  assign kick_valid = i_clrwdt && ((window_q == '0) || (count_q >= window_q));
  assign kick_early = i_clrwdt && !kick_valid;
  assign timeout    = (count_q == period_q - WDT_ONE);

  // NOTE: every *_d signal takes its hold value first, so no branch below
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    period_d   = period_q;
    window_d   = window_q;
    count_d    = count_q;
    fire_cnt_d = fire_cnt_q;
    fire_start = 1'b0;

    case (state_q)
      WDT_RUN: begin
        if (i_window_w_en) begin
          window_d = i_window_open;
        end
        // A period write restarts the count and masks any fire this cycle.
        if (i_wait_period_w_en) begin
          period_d = wdt_nonzero(i_wait_period);
          count_d  = '0;
        end else if (kick_valid) begin
          count_d = '0;
        end else if (kick_early || timeout) begin
          state_d    = WDT_FIRE;
          cause_d    = kick_early ? WDT_CAUSE_EARLY : WDT_CAUSE_TIMEOUT;
          count_d    = '0;
          fire_start = 1'b1;
          if (fire_cnt_q != 8'hFF) begin
            fire_cnt_d = fire_cnt_q + 8'd1;
          end
        end else begin
          count_d = count_q + WDT_ONE;
        end
      end
      WDT_FIRE: begin
        if (pulse_done) begin
          state_d = WDT_RUN;
          count_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= WDT_RUN;
      cause_q    <= WDT_CAUSE_NONE;
      period_q   <= wdt_nonzero(DEFAULT_PERIOD);
      window_q   <= DEFAULT_WINDOW;
      count_q    <= '0;
      fire_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      period_q   <= period_d;
      window_q   <= window_d;
      count_q    <= count_d;
      fire_cnt_q <= fire_cnt_d;
    end
  end

  wdt_pulse_stretcher u_stretch (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .start   (fire_start),
    .len     (i_rst_period),
    .pulse   (o_hardware_rst),
    .done    (pulse_done)
  );

  assign o_count    = count_q;
  assign o_state    = (state_q == WDT_FIRE);
  assign o_cause    = cause_q;
  assign o_fire_cnt = fire_cnt_q;

endmodule

// File: tb/tb_window_watchdog_mips.sv
// Self-checking bench: vector table plus hand-written corner sequences,
// expectations queued on drive and compared one cycle later.
module tb_window_watchdog_mips;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_clrwdt;
  logic [31:0] i_wait_period;
  logic        i_wait_period_w_en;
  logic [31:0] i_window_open;
  logic        i_window_w_en;
  logic [31:0] i_rst_period;
  logic        o_hardware_rst;
  logic [31:0] o_count;
  logic        o_state;
  logic [1:0]  o_cause;
  logic [7:0]  o_fire_cnt;

  typedef struct {
    string       tag;
    logic        rst;
    logic [31:0] count;
    logic        state;
    logic [1:0]  cause;
    logic [7:0]  fire_cnt;
  } exp_t;

  typedef struct {
    logic        reset;
    logic        clr;
    logic        pwe;
    logic [31:0] pw;
    logic        wwe;
    logic [31:0] win;
    logic [31:0] rp;
    exp_t        ex;
  } vec_t;

  exp_t exp_q[$];
  vec_t table_v[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  always #5 i_clk = ~i_clk;

  window_watchdog_mips #(
    .DEFAULT_PERIOD (32'd10),
    .DEFAULT_WINDOW (32'd0)
  ) dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_clrwdt           (i_clrwdt),
    .i_wait_period      (i_wait_period),
    .i_wait_period_w_en (i_wait_period_w_en),
    .i_window_open      (i_window_open),
    .i_window_w_en      (i_window_w_en),
    .i_rst_period       (i_rst_period),
    .o_hardware_rst     (o_hardware_rst),
    .o_count            (o_count),
    .o_state            (o_state),
    .o_cause            (o_cause),
    .o_fire_cnt         (o_fire_cnt)
  );

  function automatic exp_t e(input string tag, input logic rst, input logic [31:0] cnt,
                             input logic st, input logic [1:0] cause, input logic [7:0] fc);
    exp_t r;
    r.tag = tag; r.rst = rst; r.count = cnt; r.state = st; r.cause = cause; r.fire_cnt = fc;
    return r;
  endfunction

  function automatic vec_t mk(input logic reset, input logic clr, input logic pwe,
                              input logic [31:0] pw, input logic wwe, input logic [31:0] win,
                              input logic [31:0] rp, input exp_t ex);
    vec_t v;
    v.reset = reset; v.clr = clr; v.pwe = pwe; v.pw = pw;
    v.wwe = wwe; v.win = win; v.rp = rp; v.ex = ex;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] rp, input exp_t ex);
    return mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rp, ex);
  endfunction

  function automatic vec_t kick(input logic [31:0] rp, input exp_t ex);
    return mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, rp, ex);
  endfunction

  function automatic vec_t pwr(input logic [31:0] pw, input logic [31:0] rp, input exp_t ex);
    return mk(1'b0, 1'b0, 1'b1, pw, 1'b0, 32'd0, rp, ex);
  endfunction

  function automatic vec_t rst_v(input string tag);
    return mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd1, e(tag, 1'b0, 32'd0, 1'b0, 2'd0, 8'd0));
  endfunction

  task automatic check(input exp_t want);
    vectors_applied++;
    if (o_hardware_rst !== want.rst || o_count !== want.count || o_state !== want.state ||
        o_cause !== want.cause || o_fire_cnt !== want.fire_cnt) begin
      miscompares++;
      $display("FAIL %s: got rst=%0b count=%0d state=%0b cause=%0d fire_cnt=%0d, expected rst=%0b count=%0d state=%0b cause=%0d fire_cnt=%0d",
               want.tag, o_hardware_rst, o_count, o_state, o_cause, o_fire_cnt,
               want.rst, want.count, want.state, want.cause, want.fire_cnt);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t want;
    i_reset            = v.reset;
    i_clrwdt           = v.clr;
    i_wait_period_w_en = v.pwe;
    i_wait_period      = v.pw;
    i_window_w_en      = v.wwe;
    i_window_open      = v.win;
    i_rst_period       = v.rp;
    exp_q.push_back(v.ex);
    @(posedge i_clk);
    #1;
    want = exp_q.pop_front();
    check(want);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    // Defaults: period 10, no kicks, 3-cycle pulse.
    table_v.push_back(rst_v("dflt_reset"));
    for (int k = 1; k <= 9; k++)
      table_v.push_back(idle(32'd3, e("dflt_count", 1'b0, k, 1'b0, 2'd0, 8'd0)));
    for (int k = 0; k < 3; k++)
      table_v.push_back(idle(32'd3, e("dflt_fire", 1'b1, 32'd0, 1'b1, 2'd1, 8'd1)));
    table_v.push_back(idle(32'd3, e("dflt_pulse_end", 1'b0, 32'd0, 1'b0, 2'd1, 8'd1)));
    table_v.push_back(idle(32'd3, e("dflt_recount", 1'b0, 32'd1, 1'b0, 2'd1, 8'd1)));

    // Early kick: window 4, period 8.
    table_v.push_back(rst_v("early_reset"));
    table_v.push_back(mk(1'b0, 1'b0, 1'b1, 32'd8, 1'b1, 32'd4, 32'd2,
                         e("early_cfg", 1'b0, 32'd0, 1'b0, 2'd0, 8'd0)));
    table_v.push_back(idle(32'd2, e("early_cnt1", 1'b0, 32'd1, 1'b0, 2'd0, 8'd0)));
    table_v.push_back(idle(32'd2, e("early_cnt2", 1'b0, 32'd2, 1'b0, 2'd0, 8'd0)));
    table_v.push_back(kick(32'd2, e("early_fire", 1'b1, 32'd0, 1'b1, 2'd2, 8'd1)));
    table_v.push_back(idle(32'd2, e("early_hold", 1'b1, 32'd0, 1'b1, 2'd2, 8'd1)));
    table_v.push_back(idle(32'd2, e("early_end", 1'b0, 32'd0, 1'b0, 2'd2, 8'd1)));
    for (int k = 1; k <= 4; k++)
      table_v.push_back(idle(32'd2, e("early_recount", 1'b0, k, 1'b0, 2'd2, 8'd1)));
    table_v.push_back(kick(32'd2, e("early_kick_at_window", 1'b0, 32'd0, 1'b0, 2'd2, 8'd1)));
    table_v.push_back(idle(32'd2, e("early_after_kick", 1'b0, 32'd1, 1'b0, 2'd2, 8'd1)));
    table_v.push_back(kick(32'd2, e("early_window_kept", 1'b1, 32'd0, 1'b1, 2'd2, 8'd2)));
    table_v.push_back(idle(32'd2, e("early_hold2", 1'b1, 32'd0, 1'b1, 2'd2, 8'd2)));
    table_v.push_back(idle(32'd2, e("early_end2", 1'b0, 32'd0, 1'b0, 2'd2, 8'd2)));

    // Period write coincident with count == period-1.
    table_v.push_back(rst_v("wr_reset"));
    for (int k = 1; k <= 9; k++)
      table_v.push_back(idle(32'd1, e("wr_count", 1'b0, k, 1'b0, 2'd0, 8'd0)));
    table_v.push_back(pwr(32'd20, 32'd1, e("wr_vs_timeout", 1'b0, 32'd0, 1'b0, 2'd0, 8'd0)));
    for (int k = 1; k <= 19; k++)
      table_v.push_back(idle(32'd1, e("wr_count20", 1'b0, k, 1'b0, 2'd0, 8'd0)));
    table_v.push_back(idle(32'd1, e("wr_fire20", 1'b1, 32'd0, 1'b1, 2'd1, 8'd1)));
    table_v.push_back(idle(32'd1, e("wr_len1_end", 1'b0, 32'd0, 1'b0, 2'd1, 8'd1)));
    table_v.push_back(pwr(32'd0, 32'd1, e("wr_zero", 1'b0, 32'd0, 1'b0, 2'd1, 8'd1)));
    table_v.push_back(idle(32'd1, e("p0_fire_a", 1'b1, 32'd0, 1'b1, 2'd1, 8'd2)));
    table_v.push_back(idle(32'd1, e("p0_run_a", 1'b0, 32'd0, 1'b0, 2'd1, 8'd2)));
    table_v.push_back(idle(32'd1, e("p0_fire_b", 1'b1, 32'd0, 1'b1, 2'd1, 8'd3)));
    table_v.push_back(idle(32'd1, e("p0_run_b", 1'b0, 32'd0, 1'b0, 2'd1, 8'd3)));

    foreach (table_v[i]) apply(table_v[i]);

    // Periodic kicks every 5 cycles with period 8.
    apply(rst_v("per_reset"));
    apply(pwr(32'd8, 32'd3, e("per_cfg", 1'b0, 32'd0, 1'b0, 2'd0, 8'd0)));
    for (int c = 1; c <= 100; c++) begin
      if (c % 5 == 0)
        apply(kick(32'd3, e("per_kick", 1'b0, 32'd0, 1'b0, 2'd0, 8'd0)));
      else
        apply(idle(32'd3, e("per_count", 1'b0, c % 5, 1'b0, 2'd0, 8'd0)));
    end

    // Continuous kicks with window 0 hold the count at 0 past the period.
    apply(rst_v("cont_reset"));
    for (int k = 0; k < 15; k++)
      apply(kick(32'd3, e("cont_kick", 1'b0, 32'd0, 1'b0, 2'd0, 8'd0)));
    apply(idle(32'd3, e("cont_release", 1'b0, 32'd1, 1'b0, 2'd0, 8'd0)));

    // External reset on the 4th cycle of a 10-cycle pulse.
    apply(rst_v("mid_reset0"));
    apply(pwr(32'd2, 32'd10, e("mid_cfg", 1'b0, 32'd0, 1'b0, 2'd0, 8'd0)));
    apply(idle(32'd10, e("mid_cnt1", 1'b0, 32'd1, 1'b0, 2'd0, 8'd0)));
    for (int k = 0; k < 4; k++)
      apply(idle(32'd10, e("mid_fire", 1'b1, 32'd0, 1'b1, 2'd1, 8'd1)));
    apply(rst_v("mid_abort"));
    for (int k = 1; k <= 9; k++)
      apply(idle(32'd10, e("mid_default_period", 1'b0, k, 1'b0, 2'd0, 8'd0)));
    apply(idle(32'd10, e("mid_default_fire", 1'b1, 32'd0, 1'b1, 2'd1, 8'd1)));

    // Kicks and writes during a 5-cycle pulse are ignored.
    apply(rst_v("ign_reset"));
    apply(pwr(32'd3, 32'd5, e("ign_cfg", 1'b0, 32'd0, 1'b0, 2'd0, 8'd0)));
    apply(idle(32'd5, e("ign_cnt1", 1'b0, 32'd1, 1'b0, 2'd0, 8'd0)));
    apply(idle(32'd5, e("ign_cnt2", 1'b0, 32'd2, 1'b0, 2'd0, 8'd0)));
    apply(idle(32'd5, e("ign_fire", 1'b1, 32'd0, 1'b1, 2'd1, 8'd1)));
    for (int k = 0; k < 4; k++)
      apply(mk(1'b0, 1'b1, 1'b1, 32'd50, 1'b1, 32'd100, 32'd5,
               e("ign_hold", 1'b1, 32'd0, 1'b1, 2'd1, 8'd1)));
    apply(mk(1'b0, 1'b1, 1'b1, 32'd50, 1'b1, 32'd100, 32'd5,
             e("ign_end", 1'b0, 32'd0, 1'b0, 2'd1, 8'd1)));
    apply(idle(32'd5, e("ign_cnt1b", 1'b0, 32'd1, 1'b0, 2'd1, 8'd1)));
    apply(kick(32'd5, e("ign_window_unchanged", 1'b0, 32'd0, 1'b0, 2'd1, 8'd1)));
    apply(idle(32'd5, e("ign_cnt1c", 1'b0, 32'd1, 1'b0, 2'd1, 8'd1)));
    apply(idle(32'd5, e("ign_cnt2c", 1'b0, 32'd2, 1'b0, 2'd1, 8'd1)));
    apply(idle(32'd5, e("ign_period_unchanged", 1'b1, 32'd0, 1'b1, 2'd1, 8'd2)));

    // Fire counter saturates at 255.
    apply(rst_v("sat_reset"));
    apply(pwr(32'd0, 32'd1, e("sat_cfg", 1'b0, 32'd0, 1'b0, 2'd0, 8'd0)));
    for (int k = 1; k <= 257; k++) begin
      apply(idle(32'd1, e("sat_fire", 1'b1, 32'd0, 1'b1, 2'd1, (k > 255) ? 8'd255 : 8'(k))));
      apply(idle(32'd1, e("sat_run", 1'b0, 32'd0, 1'b0, 2'd1, (k > 255) ? 8'd255 : 8'(k))));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
